// File: rtl/ifb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifb_pkg
// Brief   : Shared types and constants for the instruction-fetch buffer.
// Revision: 1.0
// ============================================================================
package ifb_pkg;

    localparam int IFB_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifb_entry_t;

    typedef enum logic [1:0] {
        IFB_BOOT  = 2'd0,
        IFB_RUN   = 2'd1,
        IFB_DRAIN = 2'd2
    } ifb_state_t;

endpackage
`default_nettype wire

// File: rtl/ifb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ifb_fifo
// Brief   : Circular-buffer queue of fetched {pc, instr} entries with count.
// Revision: 1.0
// ============================================================================
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter int DEPTH = IFB_DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [63:0]                push_data_i,
    input  logic                       pop_i,
    output logic [63:0]                head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == C_FULL);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_buffer
// Brief   : Credit-based instruction prefetch queue with flush/redirect.
//           Define IFB_BYPASS_EN for a zero-latency path into an empty queue.
// Revision: 1.0
// ============================================================================
module ifetch_buffer
    import ifb_pkg::*;
#(
    parameter int          DEPTH    = IFB_DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);
    localparam logic [1:0]  C_BOOT  = IFB_BOOT;
    localparam logic [1:0]  C_RUN   = IFB_RUN;
    localparam logic [1:0]  C_DRAIN = IFB_DRAIN;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_sum;
    logic [CW-1:0] w_outst_nxt;
    logic          w_empty, w_full;
    logic          w_grant, w_accept, w_bypass, w_push, w_pop;
    ifb_entry_t    w_push_entry;
    ifb_entry_t    w_head;
    logic [63:0]   w_head_raw;

    assign w_credit_sum = {1'b0, w_count} + {1'b0, outst_q};
    assign mem_req      = (state_q == C_RUN) && !flush && (w_credit_sum < C_DEPTH);
    assign mem_addr     = fetch_pc_q;
    assign w_grant      = mem_req && mem_gnt;
    assign w_accept     = mem_rvalid && (state_q == C_RUN) && !flush;

`ifdef IFB_BYPASS_EN
    assign w_bypass  = w_accept && w_empty && out_ready;
    assign out_valid = !w_empty || w_bypass;
    assign out_pc    = w_bypass ? resp_pc_q : (w_empty ? 32'h0 : w_head.pc);
    assign out_instr = w_bypass ? mem_rdata : (w_empty ? 32'h0 : w_head.instr);
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_pc    = w_empty ? 32'h0 : w_head.pc;
    assign out_instr = w_empty ? 32'h0 : w_head.instr;
`endif

    assign w_push       = w_accept && !w_bypass;
    assign w_pop        = !w_empty && out_ready && !flush;
    assign w_push_entry = '{pc: resp_pc_q, instr: mem_rdata};
    assign w_head       = w_head_raw;

    always_comb begin
        w_outst_nxt = outst_q;
        if (w_grant && !mem_rvalid) begin
            w_outst_nxt = outst_q + CW'(1);
        end else if (!w_grant && mem_rvalid) begin
            w_outst_nxt = outst_q - CW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = w_outst_nxt;
        discard_d  = discard_q;
        if (flush) begin
            // Every response still in flight belongs to the old stream.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = w_outst_nxt;
            state_d    = (w_outst_nxt != '0) ? C_DRAIN : C_RUN;
        end else begin
            if (w_grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_accept) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            case (state_q)
                C_BOOT: state_d = C_RUN;
                C_RUN:  state_d = C_RUN;
                C_DRAIN: begin
                    if (mem_rvalid) begin
                        discard_d = discard_q - CW'(1);
                    end
                    if (discard_d == '0) begin
                        state_d = C_RUN;
                    end
                end
                default: state_d = C_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= C_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    ifb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (flush),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head_raw),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_count)
    );

    ap_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_buffer
// Brief   : Directed self-checking bench for ifetch_buffer (DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_gnt    = 0;
    logic        mem_hold = 1'b0;
    logic [31:0] pend [$];
    logic [31:0] s_req, s_addr, s_ov, s_pc, s_instr;

`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_ready   (out_ready)
    );

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sample();
        s_req   = 32'(mem_req);
        s_addr  = mem_addr;
        s_ov    = 32'(out_valid);
        s_pc    = out_pc;
        s_instr = out_instr;
    endtask

    task automatic expect_req(input string tag, input logic [31:0] req, input logic [31:0] addr);
        check({tag, " req"}, s_req, req);
        if (req != 0) check({tag, " addr"}, s_addr, addr);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ov,
                              input logic [31:0] pc, input logic [31:0] instr);
        check({tag, " valid"}, s_ov, ov);
        check({tag, " pc"}, s_pc, pc);
        check({tag, " instr"}, s_instr, instr);
    endtask

    // One cycle: drive inputs plus a 1-cycle-latency memory, sample, advance.
    task automatic step(input logic fl, input logic [31:0] rpc, input logic rdy);
        flush       = fl;
        redirect_pc = rpc;
        out_ready   = rdy;
        if (!mem_hold && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_of(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        #1;
        sample();
        if (mem_req && mem_gnt) begin
            pend.push_back(mem_addr);
            n_gnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_hold   = 1'b0;
        pend.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        sample();
        expect_req("rst", 0, 0);
        check("rst addr", s_addr, 32'h0000_0000);
        expect_out("rst", 0, 0, 0);
        reset = 1'b0;
        n_gnt = 0;
    endtask

    initial begin
        // Streaming with out_ready=1
        do_reset();
        step(1'b0, 32'h0, 1'b1); expect_req("t1 boot", 0, 0);
        step(1'b0, 32'h0, 1'b1); expect_req("t1 c2", 1, 32'h0);
        expect_out("t1 c2", 0, 0, 0);
        step(1'b0, 32'h0, 1'b1); expect_req("t1 c3", 1, 32'h4);
        expect_out("t1 c3", 32'(BYP), 32'h0, BYP ? 32'h0000_0013 : 32'h0);
        step(1'b0, 32'h0, 1'b1); expect_req("t1 c4", 1, 32'h8);
        expect_out("t1 c4", 1, BYP ? 32'h4 : 32'h0, BYP ? 32'h0004_0013 : 32'h0000_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_out("t1 c5", 1, BYP ? 32'h8 : 32'h4, BYP ? 32'h0008_0013 : 32'h0004_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_out("t1 c6", 1, BYP ? 32'hC : 32'h8, BYP ? 32'h000C_0013 : 32'h0008_0013);

        // Backpressure: credit limit of DEPTH grants
        do_reset();
        repeat (10) step(1'b0, 32'h0, 1'b0);
        check("t2 grants", 32'(n_gnt), 32'd4);
        expect_req("t2 stall", 0, 0);
        expect_out("t2 hold", 1, 32'h0, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_req("t2 rel", 0, 0);
        expect_out("t2 rel", 1, 32'h0, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_req("t2 resume", 1, 32'h10);
        expect_out("t2 next", 1, 32'h4, 32'h0004_0013);

        // Flush with 3 outstanding requests -> DRAIN
        do_reset();
        mem_hold = 1'b1;
        repeat (4) step(1'b0, 32'h0, 1'b0);
        check("t3 grants", 32'(n_gnt), 32'd3);
        step(1'b1, 32'h100, 1'b0); expect_req("t3 flush", 0, 0);
        step(1'b0, 32'h0, 1'b0);   expect_req("t3 drain", 0, 0);
        mem_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            expect_req("t3 drop", 0, 0);
            expect_out("t3 drop", 0, 0, 0);
        end
        step(1'b0, 32'h0, 1'b0); expect_req("t3 redirect", 1, 32'h100);
        step(1'b0, 32'h0, 1'b0); expect_req("t3 next", 1, 32'h104);
        expect_out("t3 lat", 0, 0, 0);
        step(1'b0, 32'h0, 1'b0);
        expect_out("t3 first", 1, 32'h100, 32'h0100_0013);

        // Flush coinciding with rvalid and out_ready
        do_reset();
        repeat (4) step(1'b0, 32'h0, 1'b0);
        expect_out("t4 pre", 1, 32'h0, 32'h0000_0013);
        step(1'b1, 32'h200, 1'b1); expect_req("t4 flush", 0, 0);
        step(1'b0, 32'h0, 1'b0);
        expect_out("t4 empty", 0, 0, 0);
        expect_req("t4 redirect", 1, 32'h200);
        step(1'b0, 32'h0, 1'b0);
        expect_out("t4 lat", 0, 0, 0);
        step(1'b0, 32'h0, 1'b0);
        expect_out("t4 first", 1, 32'h200, 32'h0200_0013);

        // Address wrap at 0xFFFF_FFFC
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 1'b0); expect_req("t5 flush", 0, 0);
        step(1'b0, 32'h0, 1'b0); expect_req("t5 top", 1, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0); expect_req("t5 wrap", 1, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b0); expect_req("t5 after", 1, 32'h0000_0004);
        expect_out("t5 head", 1, 32'hFFFF_FFFC, 32'hFFFC_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_out("t5 pop", 1, 32'hFFFF_FFFC, 32'hFFFC_0013);
        step(1'b0, 32'h0, 1'b1);
        expect_out("t5 wrap pc", 1, 32'h0000_0000, 32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
